// File: rtl/uart_line_echo_if.sv
// Handshake bundle between the transceiver halves and the line echo stage.
// The slave side is the echo block; the master side is the transceiver (or a bench).
interface uart_line_echo_if #(
  parameter int DEPTH = 64
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    i_rx_data;
  logic          i_rx_data_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_data_valid;
  logic          i_tx_ready;
  logic          o_busy;
  logic          o_overrun;
  logic [LW-1:0] o_line_len;

  modport slave (
    input  i_rx_data, i_rx_data_valid, i_tx_ready,
    output o_tx_data, o_tx_data_valid, o_busy, o_overrun, o_line_len
  );

  modport master (
    output i_rx_data, i_rx_data_valid, i_tx_ready,
    input  o_tx_data, o_tx_data_valid, o_busy, o_overrun, o_line_len
  );
endinterface

// File: rtl/uart_line_echo.sv
// Buffers one received line, then replays it to TX under valid/ready,
// optionally followed by CR LF. Bytes arriving while replaying are dropped.
module uart_line_echo #(
  parameter int         DEPTH       = 64,
  parameter logic [7:0] TERM        = 8'h0D,
  parameter bit         APPEND_CRLF = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  uart_line_echo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_SEND_CR = 2'd2;
  localparam logic [1:0] S_SEND_LF = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_line_len;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_overrun;
  logic [7:0]    r_buf [DEPTH];

  logic          w_xfer;
  logic          w_is_term;
  logic          w_is_lf;
  logic          w_store;
  logic          w_full;
  logic          w_last;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_ptr_nxt;

  assign w_xfer      = r_tx_valid && bus.i_tx_ready;
  assign w_is_term   = (bus.i_rx_data == TERM);
  // A LF after the CR terminator would otherwise echo as an extra blank line.
  assign w_is_lf     = APPEND_CRLF && (bus.i_rx_data == 8'h0A);
  assign w_store     = (r_state == S_COLLECT) && bus.i_rx_data_valid && !w_is_term && !w_is_lf;
  assign w_count_nxt = r_count + 1'b1;
  assign w_full      = (w_count_nxt == CW'(DEPTH));
  assign w_ptr_nxt   = r_rd_ptr + 1'b1;
  assign w_last      = (w_ptr_nxt == r_line_len);

  always_ff @(posedge clk)
    if (w_store) r_buf[r_count[AW-1:0]] <= bus.i_rx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_COLLECT;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_line_len <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (bus.i_rx_data_valid && (r_state != S_COLLECT)) r_overrun <= 1'b1;
      case (r_state)
        S_COLLECT: if (bus.i_rx_data_valid) begin
          if (w_is_term) begin
            if (r_count != '0) begin
              r_line_len <= r_count;
              r_rd_ptr   <= '0;
              r_tx_data  <= r_buf[0];
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND;
            end else if (APPEND_CRLF) begin
              r_line_len <= '0;
              r_tx_data  <= 8'h0D;
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND_CR;
            end
          end else if (!w_is_lf) begin
            r_count <= w_count_nxt;
            // Full flush: buf[0] is already written since DEPTH >= 2.
            if (w_full) begin
              r_line_len <= CW'(DEPTH);
              r_rd_ptr   <= '0;
              r_tx_data  <= r_buf[0];
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND;
            end
          end
        end
        S_SEND: if (w_xfer) begin
          if (w_last) begin
            if (APPEND_CRLF) begin
              r_tx_data <= 8'h0D;
              r_state   <= S_SEND_CR;
            end else begin
              r_tx_valid <= 1'b0;
              r_count    <= '0;
              r_state    <= S_COLLECT;
            end
          end else begin
            r_rd_ptr  <= w_ptr_nxt;
            r_tx_data <= r_buf[w_ptr_nxt[AW-1:0]];
          end
        end
        S_SEND_CR: if (w_xfer) begin
          r_tx_data <= 8'h0A;
          r_state   <= S_SEND_LF;
        end
        S_SEND_LF: if (w_xfer) begin
          r_tx_valid <= 1'b0;
          r_count    <= '0;
          r_state    <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bus.o_tx_data       = r_tx_data;
  assign bus.o_tx_data_valid = r_tx_valid;
  assign bus.o_busy          = (r_state != S_COLLECT);
  assign bus.o_overrun       = r_overrun;
  assign bus.o_line_len      = r_line_len;
endmodule
